// File: rtl/msrv32_pipe_slice_chain_pkg.sv
// msrv32_pkg -- shared definitions for the msrv32 elastic pipeline register.
//
// Contents:
//   - datapath field widths (XLEN, register and CSR address widths)
//   - bit offsets of the fields inside the 36-bit control bundle
//   - the default no-op control value (all enables low)
//   - the slice occupancy state and a helper that turns it into an entry count
package msrv32_pkg;

   localparam int XLEN       = 32;
   localparam int RD_ADDR_W  = 5;
   localparam int CSR_ADDR_W = 12;

   // Control bundle layout (LSB offsets). Width fields follow each offset.
   localparam int CTRL_RD_ADDR_LSB  = 0;   // 5 bits
   localparam int CTRL_CSR_ADDR_LSB = 5;   // 12 bits
   localparam int CTRL_ALU_OP_LSB   = 17;  // 4 bits
   localparam int CTRL_LOAD_SZ_LSB  = 21;  // 2 bits
   localparam int CTRL_LOAD_UNS_BIT = 23;
   localparam int CTRL_RF_WREN_BIT  = 24;
   localparam int CTRL_CSR_WREN_BIT = 25;
   localparam int CTRL_WB_MUX_LSB   = 26;  // 3 bits
   localparam int CTRL_CSR_OP_LSB   = 29;  // 3 bits
   localparam int CTRL_MEM_WREN_BIT = 32;
   localparam int CTRL_RSVD_LSB     = 33;  // 3 bits
   localparam int CTRL_W_DEF        = 36;

   // All-zero bundle: every write enable low, so a bubble is harmless downstream.
   localparam logic [CTRL_W_DEF-1:0] CTRL_NOP_DEF = '0;

   // Slice occupancy: EMPTY, main only, main + skid.
   typedef enum logic [1:0] {
      SLICE_EMPTY = 2'd0,
      SLICE_ONE   = 2'd1,
      SLICE_TWO   = 2'd2
   } slice_state_e;

   function automatic logic [1:0] slice_count(input slice_state_e s);
      logic [1:0] n;
      n = 2'd0;
      case (s)
         SLICE_ONE: n = 2'd1;
         SLICE_TWO: n = 2'd2;
         default:   n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/msrv32_pipe_slice_chain_slice.sv
// msrv32_skid_slice -- one skid-buffered elastic register slice.
//
// Handshake: an entry moves across a port on any cycle where that port's
// valid and ready are both high. in_ready_o depends only on registered state
// (skid empty), so ready never chains combinationally through slices.
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   flush_i          drop every held entry at the next edge
//   in_valid_i/in_ready_o/in_data_i     upstream side
//   out_valid_o/out_ready_i/out_data_o  downstream side (out_data_o = main register)
//   state_o          debug view of the occupancy state
module msrv32_skid_slice
   import msrv32_pkg::*;
#(
   parameter int           W          = 8,
   parameter logic [W-1:0] RST_VAL    = '0,
   // Bits selected by FLUSH_MASK are loaded from FLUSH_VAL on flush; the rest hold.
   parameter logic [W-1:0] FLUSH_MASK = '0,
   parameter logic [W-1:0] FLUSH_VAL  = '0
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o,
   output slice_state_e state_o
);

   slice_state_e state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         push, pop;

   assign in_ready_o  = (state_q != SLICE_TWO);
   assign out_valid_o = (state_q != SLICE_EMPTY);
   assign out_data_o  = main_q;
   assign state_o     = state_q;

   assign push = in_valid_i && in_ready_o;
   assign pop  = out_valid_o && out_ready_i;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         SLICE_EMPTY: begin
            if (push) begin
               state_d = SLICE_ONE;
               main_d  = in_data_i;
            end
         end
         SLICE_ONE: begin
            if (push && !pop) begin
               state_d = SLICE_TWO;
               skid_d  = in_data_i;
            end else if (push && pop) begin
               main_d  = in_data_i;
            end else if (pop) begin
               state_d = SLICE_EMPTY;
            end
         end
         SLICE_TWO: begin
            if (pop) begin
               state_d = SLICE_ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = SLICE_EMPTY;
      endcase
      // Flush overrides any push/pop: payload bits are left as they were,
      // masked (control) bits return to their idle value.
      if (flush_i) begin
         state_d = SLICE_EMPTY;
         main_d  = (main_q & ~FLUSH_MASK) | (FLUSH_VAL & FLUSH_MASK);
         skid_d  = (skid_q & ~FLUSH_MASK) | (FLUSH_VAL & FLUSH_MASK);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= SLICE_EMPTY;
         main_q  <= RST_VAL;
         skid_q  <= RST_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/msrv32_pipe_slice_chain.sv
// msrv32_pipe_slice_chain -- parametrised elastic pipeline register for the
// msrv32 datapath. Carries a DATA_W payload and a CTRL_W control bundle through
// DEPTH (1..4) cascaded skid slices; stalls without bubbles, flushes on a taken
// branch, and shows CTRL_NOP on the control output whenever the head is empty.
//
// Ports:
//   clk_in, reset_in         clock, synchronous active-high reset
//   branch_taken_in          flush every in-flight entry
//   in_valid_in/in_ready_out/in_data_in/in_ctrl_in      upstream side
//   out_valid_out/out_ready_in/out_data_out/out_ctrl_out downstream side
//   occupancy_out            number of valid entries held (0..2*DEPTH)
module msrv32_pipe_slice_chain
   import msrv32_pkg::*;
#(
   parameter int                DATA_W   = 192,
   parameter int                CTRL_W   = 36,
   parameter int                DEPTH    = 1,
   // Same value as msrv32_pkg::CTRL_NOP_DEF, written width-agnostic.
   parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
   localparam int               OCC_W    = $clog2(2*DEPTH+1)
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              branch_taken_in,
   input  logic              in_valid_in,
   output logic              in_ready_out,
   input  logic [DATA_W-1:0] in_data_in,
   input  logic [CTRL_W-1:0] in_ctrl_in,
   output logic              out_valid_out,
   input  logic              out_ready_in,
   output logic [DATA_W-1:0] out_data_out,
   output logic [CTRL_W-1:0] out_ctrl_out,
   output logic [OCC_W-1:0]  occupancy_out
);

   localparam int W = DATA_W + CTRL_W;

   // Slice word is {ctrl, data}; reset clears data and idles ctrl, flush only idles ctrl.
   localparam logic [W-1:0] IDLE_WORD  = {CTRL_NOP, {DATA_W{1'b0}}};
   localparam logic [W-1:0] CTRL_MASK  = {{CTRL_W{1'b1}}, {DATA_W{1'b0}}};

   // Link k feeds slice k; link DEPTH is the chain output.
   logic [DEPTH:0]        lnk_valid;
   logic [DEPTH:0]        lnk_ready;
   logic [DEPTH:0][W-1:0] lnk_data;
   slice_state_e          slice_state [DEPTH];
   logic [OCC_W-1:0]      occ_sum;

   assign lnk_valid[0]     = in_valid_in;
   assign lnk_data[0]      = {in_ctrl_in, in_data_in};
   assign in_ready_out     = lnk_ready[0];
   assign lnk_ready[DEPTH] = out_ready_in;
   assign out_valid_out    = lnk_valid[DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_slice
      msrv32_skid_slice #(
         .W          (W),
         .RST_VAL    (IDLE_WORD),
         .FLUSH_MASK (CTRL_MASK),
         .FLUSH_VAL  (IDLE_WORD)
      ) u_slice (
         .clk_i       (clk_in),
         .reset_i     (reset_in),
         .flush_i     (branch_taken_in),
         .in_valid_i  (lnk_valid[k]),
         .in_ready_o  (lnk_ready[k]),
         .in_data_i   (lnk_data[k]),
         .out_valid_o (lnk_valid[k+1]),
         .out_ready_i (lnk_ready[k+1]),
         .out_data_o  (lnk_data[k+1]),
         .state_o     (slice_state[k])
      );
   end

   assign out_data_out = lnk_data[DEPTH][DATA_W-1:0];
   assign out_ctrl_out = out_valid_out ? lnk_data[DEPTH][W-1:DATA_W] : CTRL_NOP;

   // Sum of the registered slice states, i.e. the valid bits after the last edge.
   always_comb begin
      occ_sum = '0;
      for (int k = 0; k < DEPTH; k++) begin
         occ_sum = occ_sum + OCC_W'(slice_count(slice_state[k]));
      end
   end

   assign occupancy_out = occ_sum;

endmodule

// File: tb/tb_msrv32_pipe_slice_chain.sv
// Directed and random checks of msrv32_pipe_slice_chain. Two instances share
// the stimulus: u_d1 (DEPTH=1) and u_d2 (DEPTH=2). Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_msrv32_pipe_slice_chain;

   localparam int DW = 192;
   localparam int CW = 36;
   localparam logic [CW-1:0] NOP = '0;

   logic          clk = 1'b0;
   logic          rst;
   logic          br;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_ready;

   logic          rdy1, ov1, rdy2, ov2;
   logic [DW-1:0] od1, od2;
   logic [CW-1:0] oc1, oc2;
   logic [1:0]    occ1;
   logic [2:0]    occ2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   msrv32_pipe_slice_chain #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(1)) u_d1 (
      .clk_in(clk), .reset_in(rst), .branch_taken_in(br),
      .in_valid_in(in_valid), .in_ready_out(rdy1), .in_data_in(in_data), .in_ctrl_in(in_ctrl),
      .out_valid_out(ov1), .out_ready_in(out_ready), .out_data_out(od1), .out_ctrl_out(oc1),
      .occupancy_out(occ1)
   );

   msrv32_pipe_slice_chain #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(2)) u_d2 (
      .clk_in(clk), .reset_in(rst), .branch_taken_in(br),
      .in_valid_in(in_valid), .in_ready_out(rdy2), .in_data_in(in_data), .in_ctrl_in(in_ctrl),
      .out_valid_out(ov2), .out_ready_in(out_ready), .out_data_out(od2), .out_ctrl_out(oc2),
      .occupancy_out(occ2)
   );

   function automatic logic [CW-1:0] ctrl_of(input logic [15:0] d);
      return {4'h8, 24'h0, d[7:0]};
   endfunction

   task automatic drive(input logic v, input logic [15:0] d);
      in_valid = v;
      in_data  = DW'(d);
      in_ctrl  = ctrl_of(d);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; br = 1'b0; out_ready = 1'b0;
      drive(1'b0, 16'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; br = 1'b0; out_ready = 1'b0;
      drive(1'b1, 16'h55);
      repeat (2) @(negedge clk);
      n_cmp++; if (ov1 !== 1'b0)  begin n_bad++; $display("FAIL rst_ov1 got %b exp 0", ov1); end
      n_cmp++; if (oc1 !== NOP)   begin n_bad++; $display("FAIL rst_oc1 got %h exp %h", oc1, NOP); end
      n_cmp++; if (occ1 !== 2'd0) begin n_bad++; $display("FAIL rst_occ1 got %0d exp 0", occ1); end
      n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL rst_rdy1 got %b exp 1", rdy1); end
      n_cmp++; if (od1 !== '0)    begin n_bad++; $display("FAIL rst_od1 got %h exp 0", od1); end
      n_cmp++; if (ov2 !== 1'b0)  begin n_bad++; $display("FAIL rst_ov2 got %b exp 0", ov2); end
      n_cmp++; if (oc2 !== NOP)   begin n_bad++; $display("FAIL rst_oc2 got %h exp %h", oc2, NOP); end
      n_cmp++; if (occ2 !== 3'd0) begin n_bad++; $display("FAIL rst_occ2 got %0d exp 0", occ2); end
      n_cmp++; if (rdy2 !== 1'b1) begin n_bad++; $display("FAIL rst_rdy2 got %b exp 1", rdy2); end
      rst = 1'b0;
      drive(1'b0, 16'h0);
   endtask

   // DEPTH=2: entry driven at falling edge 0 shows at falling edge 2, then one per cycle.
   task automatic test_streaming();
      logic          e_ov;
      logic [2:0]    e_occ;
      logic [15:0]   e_d;
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         e_ov  = (c >= 2) && (c <= 9);
         e_d   = 16'(c - 1);
         e_occ = (c == 0 || c >= 10) ? 3'd0 : (c == 1 || c == 9) ? 3'd1 : 3'd2;
         n_cmp++; if (ov2 !== e_ov) begin n_bad++; $display("FAIL stream_ov c=%0d got %b exp %b", c, ov2, e_ov); end
         n_cmp++; if (occ2 !== e_occ) begin n_bad++; $display("FAIL stream_occ c=%0d got %0d exp %0d", c, occ2, e_occ); end
         if (e_ov) begin
            n_cmp++; if (od2 !== DW'(e_d)) begin n_bad++; $display("FAIL stream_data c=%0d got %h exp %h", c, od2, e_d); end
            n_cmp++; if (oc2 !== ctrl_of(e_d)) begin n_bad++; $display("FAIL stream_ctrl c=%0d got %h exp %h", c, oc2, ctrl_of(e_d)); end
         end else begin
            n_cmp++; if (oc2 !== NOP) begin n_bad++; $display("FAIL stream_nop c=%0d got %h exp %h", c, oc2, NOP); end
         end
         if (c < 8) begin
            n_cmp++; if (rdy2 !== 1'b1) begin n_bad++; $display("FAIL stream_rdy c=%0d got %b exp 1", c, rdy2); end
            drive(1'b1, 16'(c + 1));
         end else begin
            drive(1'b0, 16'h0);
         end
      end
   endtask

   // DEPTH=1 with downstream stalled: two accepts fill the slice.
   task automatic test_backpressure();
      logic [15:0] got[$];
      logic [15:0] exp_q[$];
      logic        acc;
      do_reset();
      out_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL bp_rdy0 got %b exp 1", rdy1); end
      drive(1'b1, 16'h000A);
      @(negedge clk);
      n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL bp_rdy1 got %b exp 1", rdy1); end
      drive(1'b1, 16'h000B);
      @(negedge clk);
      n_cmp++; if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL bp_full_rdy got %b exp 0", rdy1); end
      n_cmp++; if (occ1 !== 2'd2) begin n_bad++; $display("FAIL bp_full_occ got %0d exp 2", occ1); end
      drive(1'b1, 16'h000C);
      @(negedge clk);
      n_cmp++; if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL bp_hold_rdy got %b exp 0", rdy1); end
      n_cmp++; if (occ1 !== 2'd2) begin n_bad++; $display("FAIL bp_hold_occ got %0d exp 2", occ1); end
      n_cmp++; if (od1 !== DW'(16'h000A)) begin n_bad++; $display("FAIL bp_hold_data got %h exp a", od1); end
      n_cmp++; if (oc1 !== ctrl_of(16'h000A)) begin n_bad++; $display("FAIL bp_hold_ctrl got %h exp %h", oc1, ctrl_of(16'h000A)); end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (ov1) got.push_back(od1[15:0]);
         acc = in_valid && rdy1;
         @(negedge clk);
         if (acc) drive(1'b0, 16'h0);
      end
      exp_q = '{16'h000A, 16'h000B, 16'h000C};
      n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_count got %0d exp %0d", got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_cmp++;
         if (i >= got.size()) begin n_bad++; $display("FAIL bp_order[%0d] got none exp %h", i, exp_q[i]); end
         else if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_order[%0d] got %h exp %h", i, got[i], exp_q[i]); end
      end
      n_cmp++; if (ov1 !== 1'b0) begin n_bad++; $display("FAIL bp_drained got %b exp 0", ov1); end
   endtask

   // DEPTH=2 holding three entries, flush coinciding with a push of 0xD.
   task automatic test_flush();
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         drive(1'b1, 16'(i));
      end
      @(negedge clk);
      n_cmp++; if (occ2 !== 3'd3) begin n_bad++; $display("FAIL fl_pre_occ got %0d exp 3", occ2); end
      n_cmp++; if (od2 !== DW'(16'h1)) begin n_bad++; $display("FAIL fl_pre_head got %h exp 1", od2); end
      n_cmp++; if (rdy2 !== 1'b1) begin n_bad++; $display("FAIL fl_pre_rdy got %b exp 1", rdy2); end
      drive(1'b1, 16'h000D);
      br = 1'b1;
      @(negedge clk);
      br = 1'b0;
      drive(1'b0, 16'h0);
      n_cmp++; if (occ2 !== 3'd0) begin n_bad++; $display("FAIL fl_occ got %0d exp 0", occ2); end
      n_cmp++; if (ov2 !== 1'b0) begin n_bad++; $display("FAIL fl_ov got %b exp 0", ov2); end
      n_cmp++; if (oc2 !== NOP) begin n_bad++; $display("FAIL fl_ctrl got %h exp %h", oc2, NOP); end
      n_cmp++; if (rdy2 !== 1'b1) begin n_bad++; $display("FAIL fl_rdy got %b exp 1", rdy2); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++; if (ov2 !== 1'b0) begin n_bad++; $display("FAIL fl_ghost[%0d] got %b exp 0 data %h", i, ov2, od2); end
      end
      drive(1'b1, 16'h000E);
      @(negedge clk);
      drive(1'b0, 16'h0);
      @(negedge clk);
      n_cmp++; if (ov2 !== 1'b1) begin n_bad++; $display("FAIL fl_after_ov got %b exp 1", ov2); end
      n_cmp++; if (od2 !== DW'(16'h000E)) begin n_bad++; $display("FAIL fl_after_data got %h exp e", od2); end
   endtask

   // Random valid/ready against a reference queue per instance.
   task automatic test_random();
      logic [15:0] exp_q1[$];
      logic [15:0] exp_q2[$];
      logic [15:0] d;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         n_cmp++; if (occ1 !== 2'(exp_q1.size())) begin n_bad++; $display("FAIL rnd_occ1 c=%0d got %0d exp %0d", c, occ1, exp_q1.size()); end
         n_cmp++; if (occ2 !== 3'(exp_q2.size())) begin n_bad++; $display("FAIL rnd_occ2 c=%0d got %0d exp %0d", c, occ2, exp_q2.size()); end
         if (ov1) begin
            n_cmp++; if (exp_q1.size() == 0 || od1 !== DW'(exp_q1[0])) begin n_bad++; $display("FAIL rnd_data1 c=%0d got %h", c, od1); end
         end else begin
            n_cmp++; if (oc1 !== NOP) begin n_bad++; $display("FAIL rnd_nop1 c=%0d got %h exp %h", c, oc1, NOP); end
         end
         if (ov2) begin
            n_cmp++; if (exp_q2.size() == 0 || od2 !== DW'(exp_q2[0]) || oc2 !== ctrl_of(exp_q2[0])) begin n_bad++; $display("FAIL rnd_data2 c=%0d got %h", c, od2); end
         end else begin
            n_cmp++; if (oc2 !== NOP) begin n_bad++; $display("FAIL rnd_nop2 c=%0d got %h exp %h", c, oc2, NOP); end
         end
         d = 16'($urandom_range(0, 65535));
         drive($urandom_range(0, 3) != 0, d);
         out_ready = ($urandom_range(0, 3) != 0) ^ (c[9] & ($urandom_range(0, 1) == 1));
         if (in_valid && rdy1) exp_q1.push_back(d);
         if (in_valid && rdy2) exp_q2.push_back(d);
         if (ov1 && out_ready && exp_q1.size() > 0) void'(exp_q1.pop_front());
         if (ov2 && out_ready && exp_q2.size() > 0) void'(exp_q2.pop_front());
      end
      @(negedge clk);
      drive(1'b0, 16'h0);
   endtask

   // Reset asserted while two entries are held and the head is being taken.
   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      @(negedge clk);
      drive(1'b1, 16'h0021);
      @(negedge clk);
      drive(1'b1, 16'h0022);
      @(negedge clk);
      n_cmp++; if (occ1 !== 2'd2) begin n_bad++; $display("FAIL rm_pre_occ got %0d exp 2", occ1); end
      drive(1'b1, 16'h0023);
      out_ready = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 16'h0);
      n_cmp++; if (ov1 !== 1'b0)  begin n_bad++; $display("FAIL rm_ov1 got %b exp 0", ov1); end
      n_cmp++; if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL rm_rdy1 got %b exp 1", rdy1); end
      n_cmp++; if (occ1 !== 2'd0) begin n_bad++; $display("FAIL rm_occ1 got %0d exp 0", occ1); end
      n_cmp++; if (od1 !== '0)    begin n_bad++; $display("FAIL rm_od1 got %h exp 0", od1); end
      n_cmp++; if (oc1 !== NOP)   begin n_bad++; $display("FAIL rm_oc1 got %h exp %h", oc1, NOP); end
      n_cmp++; if (occ2 !== 3'd0) begin n_bad++; $display("FAIL rm_occ2 got %0d exp 0", occ2); end
      n_cmp++; if (ov2 !== 1'b0)  begin n_bad++; $display("FAIL rm_ov2 got %b exp 0", ov2); end
      n_cmp++; if (od2 !== '0)    begin n_bad++; $display("FAIL rm_od2 got %h exp 0", od2); end
   endtask

   initial begin
      rst = 1'b1; br = 1'b0; out_ready = 1'b0;
      drive(1'b0, 16'h0);
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
